// File: rtl/marma_pkg.sv
// Shared Marma id map, priority classes and ring classification for the QoS router.
package marma_pkg;

  localparam int ID_W    = 5;
  localparam int AGE_W   = 3;
  localparam int SCORE_W = 5;

  // Last id of each ring segment; MARMA_APEX is the final valid point.
  localparam logic [ID_W-1:0] MARMA_BINDU_LAST = 5'd1;
  localparam logic [ID_W-1:0] MARMA_L1_LAST    = 5'd4;
  localparam logic [ID_W-1:0] MARMA_L2_LAST    = 5'd7;
  localparam logic [ID_W-1:0] MARMA_L3_LAST    = 5'd10;
  localparam logic [ID_W-1:0] MARMA_MEM_LAST   = 5'd13;
  localparam logic [ID_W-1:0] MARMA_APEX       = 5'd17;

  localparam logic [3:0] PRIO_BINDU   = 4'd10;
  localparam logic [3:0] PRIO_NEAR    = 4'd8;
  localparam logic [3:0] PRIO_FAR     = 4'd5;
  localparam logic [3:0] PRIO_PERIPH  = 4'd2;
  localparam logic [3:0] PRIO_APEX    = 4'd1;
  localparam logic [3:0] PRIO_INVALID = 4'd1;

  typedef enum logic [2:0] {
    RING_BINDU, RING_L1, RING_L2, RING_L3, RING_MEM, RING_IO
  } ring_e;

  typedef enum logic [1:0] {
    SLOT_FREE, SLOT_COUNT, SLOT_DONE
  } slot_state_e;

  typedef struct packed {
    slot_state_e      state;
    logic [3:0]       cnt;
    logic [AGE_W-1:0] age;
    logic [7:0]       wait_cnt;
    logic [ID_W-1:0]  id;
    logic             err;
  } slot_ctl_t;

  function automatic logic [3:0] marma_prio(input logic [ID_W-1:0] id);
    logic [3:0] prio;
    if (id <= MARMA_BINDU_LAST)    prio = PRIO_BINDU;
    else if (id <= MARMA_L2_LAST)  prio = PRIO_NEAR;
    else if (id <= MARMA_MEM_LAST) prio = PRIO_FAR;
    else if (id < MARMA_APEX)      prio = PRIO_PERIPH;
    else                           prio = PRIO_APEX;
    return prio;
  endfunction

  function automatic ring_e marma_ring(input logic [ID_W-1:0] id);
    ring_e ring;
    if (id <= MARMA_BINDU_LAST)    ring = RING_BINDU;
    else if (id <= MARMA_L1_LAST)  ring = RING_L1;
    else if (id <= MARMA_L2_LAST)  ring = RING_L2;
    else if (id <= MARMA_L3_LAST)  ring = RING_L3;
    else if (id <= MARMA_MEM_LAST) ring = RING_MEM;
    else                           ring = RING_IO;
    return ring;
  endfunction

endpackage

// File: rtl/marma_qos_router_arbiter.sv
// Combinational max-score picker over completed slots; lowest index wins ties.
module marma_age_arbiter
  import marma_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0]              eligible,
  input  logic [NUM_SLOTS-1:0][SCORE_W-1:0] score,
  output logic [NUM_SLOTS-1:0]              grant
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic               found;
  logic [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]   best_idx;

  // NOTE: every comb output gets a default before the loop so no latch is inferred,
  // and blocking '=' lets later iterations see the running best.
  always_comb begin
    grant      = '0;
    found      = 1'b0;
    best_score = '0;
    best_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      // Strict '>' keeps the earlier (lower) index on equal scores.
      if (eligible[i] && (!found || score[i] > best_score)) begin
        found      = 1'b1;
        best_score = score[i];
        best_idx   = i[IDX_W-1:0];
      end
    end
    if (found) grant[best_idx] = 1'b1;
  end

endmodule

// File: rtl/marma_qos_router.sv
// Multi-outstanding Marma router: slot array with parallel latency countdown,
// lowest-free allocation and an aging-arbitrated response register.
module marma_qos_router
  import marma_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter int         ADDR_WIDTH = 32,
  parameter int         NUM_MARMA  = 18,
  parameter int         NUM_SLOTS  = 4,
  parameter int         AGE_MAX    = 7,
  parameter logic [3:0] LAT_BINDU  = 4'd1,
  parameter logic [3:0] LAT_L1     = 4'd2,
  parameter logic [3:0] LAT_L2     = 4'd4,
  parameter logic [3:0] LAT_L3     = 4'd8,
  parameter logic [3:0] LAT_MEM    = 4'd12,
  parameter logic [3:0] LAT_IO     = 4'd15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_W-1:0]       req_marma_id,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  req_write,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ID_W-1:0]       resp_marma_id,
  output logic                  resp_err,
  output logic [7:0]            resp_cycles,
  output logic [NUM_MARMA-1:0]  marma_active,
  output logic [3:0]            current_priority,
  output logic [7:0]            critical_slack
);

  localparam logic [ID_W-1:0]  ID_LIMIT = ID_W'(NUM_MARMA);
  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(AGE_MAX);

  function automatic logic [3:0] ring_latency(input ring_e ring);
    logic [3:0] lat;
    case (ring)
      RING_BINDU: lat = LAT_BINDU;
      RING_L1:    lat = LAT_L1;
      RING_L2:    lat = LAT_L2;
      RING_L3:    lat = LAT_L3;
      RING_MEM:   lat = LAT_MEM;
      default:    lat = LAT_IO;
    endcase
    return lat;
  endfunction

  function automatic logic [3:0] slot_prio(input slot_ctl_t ctl);
    return ctl.err ? PRIO_INVALID : marma_prio(ctl.id);
  endfunction

  slot_ctl_t                       slot_q [NUM_SLOTS];
  slot_ctl_t                       slot_d [NUM_SLOTS];
  logic [DATA_WIDTH-1:0]           slot_data_q [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0]           slot_addr_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]            free_vec, done_vec, alloc, grant;
  logic [NUM_SLOTS-1:0][SCORE_W-1:0] score;
  logic                            req_id_ok;
  logic [3:0]                      req_lat;
  logic                            load_en;
  logic [DATA_WIDTH-1:0]           sel_data;
  logic [ADDR_WIDTH-1:0]           sel_addr;
  logic [ID_W-1:0]                 sel_id;
  logic                            sel_err;
  logic [7:0]                      sel_wait;
  logic [3:0]                      sel_prio;
  logic [3:0]                      resp_prio_q;

  // The write flag rides with the request into the ring; completion here ignores it.
  logic unused_write;
  assign unused_write = req_write;

  assign req_id_ok = (req_marma_id < ID_LIMIT);
  assign req_lat   = req_id_ok ? ring_latency(marma_ring(req_marma_id)) : 4'd0;
  assign req_ready = |free_vec;
  assign load_en   = !resp_valid || resp_ready;

  // Slot status, arbitration scores and the active-point map.
  always_comb begin
    free_vec     = '0;
    done_vec     = '0;
    score        = '0;
    marma_active = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_vec[i] = (slot_q[i].state == SLOT_FREE);
      done_vec[i] = (slot_q[i].state == SLOT_DONE);
      score[i]    = {1'b0, slot_prio(slot_q[i])} + SCORE_W'(slot_q[i].age);
      for (int m = 0; m < NUM_MARMA; m++) begin
        if (!free_vec[i] && !slot_q[i].err && slot_q[i].id == ID_W'(m))
          marma_active[m] = 1'b1;
      end
    end
  end

  marma_age_arbiter #(.NUM_SLOTS(NUM_SLOTS)) u_arbiter (
    .eligible (done_vec),
    .score    (score),
    .grant    (grant)
  );

  // Slot next-state: allocation, countdown, aging and release.
  always_comb begin
    logic taken;
    alloc = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (req_valid && free_vec[i] && !taken) begin
        alloc[i] = 1'b1;
        taken    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      if (!free_vec[i] && slot_q[i].wait_cnt != 8'hFF)
        slot_d[i].wait_cnt = slot_q[i].wait_cnt + 8'd1;
      case (slot_q[i].state)
        SLOT_FREE: begin
          if (alloc[i]) begin
            slot_d[i].state    = (req_lat == 4'd0) ? SLOT_DONE : SLOT_COUNT;
            slot_d[i].cnt      = req_lat;
            slot_d[i].age      = '0;
            slot_d[i].wait_cnt = '0;
            slot_d[i].id       = req_marma_id;
            slot_d[i].err      = !req_id_ok;
          end
        end
        SLOT_COUNT: begin
          slot_d[i].cnt = slot_q[i].cnt - 4'd1;
          if (slot_q[i].cnt <= 4'd1) slot_d[i].state = SLOT_DONE;
        end
        SLOT_DONE: begin
          if (load_en) begin
            if (grant[i])                   slot_d[i].state = SLOT_FREE;
            else if (slot_q[i].age != AGE_SAT) slot_d[i].age = slot_q[i].age + 1'b1;
          end
        end
        default: slot_d[i].state = SLOT_FREE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
    end
  end

  // NOTE: payload storage has no reset; slot state alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (alloc[i]) begin
        slot_data_q[i] <= req_data;
        slot_addr_q[i] <= req_addr;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    sel_id   = '0;
    sel_err  = 1'b0;
    sel_wait = '0;
    sel_prio = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (grant[i]) begin
        sel_data = slot_data_q[i];
        sel_addr = slot_addr_q[i];
        sel_id   = slot_q[i].id;
        sel_err  = slot_q[i].err;
        sel_wait = slot_q[i].wait_cnt;
        sel_prio = slot_prio(slot_q[i]);
      end
    end
  end

  // Output register: a pop and a fresh load can share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_addr     <= '0;
      resp_marma_id <= '0;
      resp_err      <= 1'b0;
      resp_cycles   <= '0;
      resp_prio_q   <= '0;
    end else if (load_en) begin
      resp_valid <= |grant;
      if (|grant) begin
        resp_data     <= sel_data;
        resp_addr     <= sel_addr;
        resp_marma_id <= sel_id;
        resp_err      <= sel_err;
        resp_cycles   <= (sel_wait == 8'hFF) ? 8'hFF : sel_wait + 8'd1;
        resp_prio_q   <= sel_prio;
      end
    end
  end

  assign current_priority = resp_valid ? resp_prio_q : 4'd0;
  assign critical_slack   = 8'd100 - (8'(current_priority) * 8'd10);

endmodule

// File: tb/tb_marma_qos_router.sv
// Directed bench for marma_qos_router: latency, ordering, back-pressure, aging, errors, reset.
module tb_marma_qos_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_marma_id;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic        req_write;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [31:0] resp_addr;
  logic [4:0]  resp_marma_id;
  logic        resp_err;
  logic [7:0]  resp_cycles;
  logic [17:0] marma_active;
  logic [3:0]  current_priority;
  logic [7:0]  critical_slack;

  int n_checks = 0;
  int n_errors = 0;

  marma_qos_router dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_marma_id     (req_marma_id),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_write        (req_write),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .resp_addr        (resp_addr),
    .resp_marma_id    (resp_marma_id),
    .resp_err         (resp_err),
    .resp_cycles      (resp_cycles),
    .marma_active     (marma_active),
    .current_priority (current_priority),
    .critical_slack   (critical_slack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] id, input logic [31:0] addr, input logic [63:0] data);
    check("send_ready", req_ready, 1'b1);
    req_valid    = 1'b1;
    req_marma_id = id;
    req_addr     = addr;
    req_data     = data;
    req_write    = addr[0];
    step();
    req_valid    = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_marma_id = '0; req_addr = '0;
    req_data = '0; req_write = 1'b0; resp_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_cycles", resp_cycles, 8'd0);
    check("rst_active", marma_active, 18'd0);
    check("rst_prio", current_priority, 4'd0);
    check("rst_slack", critical_slack, 8'd100);

    // 1: bindu request, latency 1 -> response two edges after accept
    send(5'd0, 32'h100, 64'hA5);
    check("t1_active", marma_active, 64'd1);
    check("t1_valid_e0", resp_valid, 1'b0);
    step();
    check("t1_valid_e1", resp_valid, 1'b0);
    step();
    check("t1_valid_e2", resp_valid, 1'b1);
    check("t1_data", resp_data, 64'hA5);
    check("t1_addr", resp_addr, 32'h100);
    check("t1_id", resp_marma_id, 5'd0);
    check("t1_cycles", resp_cycles, 8'd2);
    check("t1_prio", current_priority, 4'd10);
    check("t1_slack", critical_slack, 8'd0);
    step();
    check("t1_pop", resp_valid, 1'b0);
    check("t1_idle", marma_active, 18'd0);

    // 2: id 17 then id 1; id 1 overtakes
    send(5'd17, 32'h170, 64'h17);
    send(5'd1, 32'h010, 64'h01);
    for (int n = 2; n <= 17; n++) begin
      step();
      case (n)
        2: begin
          check("t2_active_both", marma_active, (64'd1 << 17) | (64'd1 << 1));
          check("t2_valid_c2", resp_valid, 1'b0);
        end
        3: begin
          check("t2_valid_c3", resp_valid, 1'b1);
          check("t2_id_c3", resp_marma_id, 5'd1);
          check("t2_cycles_c3", resp_cycles, 8'd2);
          check("t2_active_c3", marma_active, 64'd1 << 17);
        end
        4: check("t2_valid_c4", resp_valid, 1'b0);
        15: begin
          check("t2_active_c15", marma_active, 64'd1 << 17);
          check("t2_valid_c15", resp_valid, 1'b0);
        end
        16: begin
          check("t2_valid_c16", resp_valid, 1'b1);
          check("t2_id_c16", resp_marma_id, 5'd17);
          check("t2_cycles_c16", resp_cycles, 8'd16);
          check("t2_prio_c16", current_priority, 4'd1);
          check("t2_slack_c16", critical_slack, 8'd90);
          check("t2_active_c16", marma_active, 18'd0);
        end
        17: check("t2_valid_c17", resp_valid, 1'b0);
        default: ;
      endcase
    end

    // 3: fill all slots under back-pressure
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(5'd14, 32'h1400 + k, 64'h1400 + k);
    check("t3_full", req_ready, 1'b0);
    req_valid = 1'b1; req_marma_id = 5'd5; req_addr = 32'h500; req_data = 64'h500;
    step();
    req_valid = 1'b0;
    check("t3_reject_active", marma_active, 64'd1 << 14);
    check("t3_reject_ready", req_ready, 1'b0);
    repeat (16) step();
    check("t3_first_valid", resp_valid, 1'b1);
    check("t3_first_data", resp_data, 64'h1400);
    check("t3_first_cycles", resp_cycles, 8'd16);
    check("t3_slot_freed", req_ready, 1'b1);
    send(5'd14, 32'h1404, 64'h1404);
    check("t3_refull", req_ready, 1'b0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("t3_pulse_ready", req_ready, 1'b1);
    check("t3_pulse_valid", resp_valid, 1'b1);
    check("t3_pulse_data", resp_data, 64'h1401);
    resp_ready = 1'b1;
    repeat (25) step();
    check("t3_drained_valid", resp_valid, 1'b0);
    check("t3_drained_active", marma_active, 18'd0);

    // 4: aging lets an id 14 slot beat a stream of id 2 arrivals
    resp_ready = 1'b0;
    send(5'd14, 32'hE0, 64'hE0);
    send(5'd2, 32'h20, 64'h20);
    repeat (3) step();
    check("t4_filler_valid", resp_valid, 1'b1);
    check("t4_filler_id", resp_marma_id, 5'd2);
    send(5'd2, 32'h21, 64'h21);
    repeat (12) step();
    check("t4_active", marma_active, (64'd1 << 14) | (64'd1 << 2));
    for (int r = 1; r <= 7; r++) begin
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("t4_round_id", resp_marma_id, (r < 7) ? 5'd2 : 5'd14);
      if (r < 7) begin
        send(5'd2, 32'h21 + r, 64'h21 + r);
        repeat (2) step();
      end
    end
    check("t4_winner_prio", current_priority, 4'd2);
    check("t4_winner_data", resp_data, 64'hE0);
    resp_ready = 1'b1;
    repeat (4) step();
    check("t4_drained", resp_valid, 1'b0);

    // 5: invalid id completes immediately with an error
    resp_ready = 1'b0;
    send(5'd20, 32'h2000, 64'h55);
    check("t5_active", marma_active, 18'd0);
    check("t5_valid_e0", resp_valid, 1'b0);
    step();
    check("t5_valid", resp_valid, 1'b1);
    check("t5_err", resp_err, 1'b1);
    check("t5_id", resp_marma_id, 5'd20);
    check("t5_prio", current_priority, 4'd1);
    check("t5_slack", critical_slack, 8'd90);
    check("t5_cycles", resp_cycles, 8'd1);
    repeat (3) step();
    check("t5_hold_valid", resp_valid, 1'b1);
    check("t5_hold_data", resp_data, 64'h55);
    check("t5_hold_id", resp_marma_id, 5'd20);
    resp_ready = 1'b1;
    step();
    check("t5_pop", resp_valid, 1'b0);

    // 6: asynchronous reset with slots busy
    resp_ready = 1'b0;
    send(5'd20, 32'h3000, 64'h66);
    send(5'd14, 32'h3001, 64'h67);
    send(5'd14, 32'h3002, 64'h68);
    send(5'd14, 32'h3003, 64'h69);
    check("t6_pre_valid", resp_valid, 1'b1);
    check("t6_pre_err", resp_err, 1'b1);
    check("t6_pre_active", marma_active, 64'd1 << 14);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", resp_valid, 1'b0);
    check("t6_err", resp_err, 1'b0);
    check("t6_id", resp_marma_id, 5'd0);
    check("t6_data", resp_data, 64'd0);
    check("t6_addr", resp_addr, 32'd0);
    check("t6_cycles", resp_cycles, 8'd0);
    check("t6_active", marma_active, 18'd0);
    check("t6_prio", current_priority, 4'd0);
    check("t6_slack", critical_slack, 8'd100);
    check("t6_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      step();
      if (resp_valid) seen++;
    end
    check("t6_no_stale", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
